// File: rtl/coeff_rom_pkg.sv
// coeff_rom_pkg: shared widths, ROM region bases and engine state encoding
package coeff_rom_pkg;
  localparam int ADDR_W = 12;
  localparam int DATA_W = 32;
  localparam logic [11:0] MDCT  = 12'h000;
  localparam logic [11:0] WIN   = 12'h400;
  localparam logic [11:0] QUANT = 12'h600;
  localparam logic [11:0] PSY   = 12'h800;
  localparam logic [11:0] ENT   = 12'hA00;
  localparam logic [11:0] RSVD  = 12'hC00;
  typedef enum logic [1:0] {IDLE, FETCH, DRAIN} state_e;
endpackage

// File: rtl/coeff_fetch_engine_if.sv
// coeff_fetch_if: command handshake plus output stream; slave = engine side, master = requester/consumer side
interface coeff_fetch_if #(
  parameter int ADDR_W = coeff_rom_pkg::ADDR_W,
  parameter int DATA_W = coeff_rom_pkg::DATA_W
);
  logic              cmd_valid;
  logic              cmd_ready;
  logic [ADDR_W-1:0] cmd_base;
  logic [12:0]       cmd_count;
  logic [3:0]        cmd_stride;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic              out_last;
  modport slave (
    input  cmd_valid, cmd_base, cmd_count, cmd_stride, out_ready,
    output cmd_ready, out_valid, out_data, out_last
  );
  modport master (
    output cmd_valid, cmd_base, cmd_count, cmd_stride, out_ready,
    input  cmd_ready, out_valid, out_data, out_last
  );
endinterface

// File: rtl/coeff_fetch_fifo.sv
// coeff_fetch_fifo: 2-entry valid/ready FIFO; ports clk, rst_n, in_* (write), out_* (read), count (occupancy)
module coeff_fetch_fifo #(
  parameter int W = 33
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data,
  output logic [1:0]   count
);
  logic [W-1:0] mem_q [2];
  logic [W-1:0] mem_d [2];
  logic wr_q, wr_d, rd_q, rd_d, push, pop;
  logic [1:0] cnt_q, cnt_d;
  assign in_ready  = cnt_q != 2'd2;
  assign out_valid = cnt_q != 2'd0;
  assign out_data  = mem_q[rd_q];
  assign count     = cnt_q;
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;
  always_comb begin
    mem_d = mem_q;
    if (push) mem_d[wr_q] = in_data;
    wr_d  = wr_q ^ push;
    rd_d  = rd_q ^ pop;
    cnt_d = cnt_q + {1'b0, push} - {1'b0, pop};
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      wr_q     <= 1'b0;
      rd_q     <= 1'b0;
      cnt_q    <= 2'd0;
    end else begin
      mem_q <= mem_d;
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end
endmodule

// File: rtl/coeff_fetch_engine.sv
// coeff_fetch_engine: strided coefficient ROM fetcher; ports clk, rst_n, bus (cmd + out stream), rom_addr/rom_ren/rom_rdata, busy, done
module coeff_fetch_engine #(
  parameter int ADDR_W = coeff_rom_pkg::ADDR_W,
  parameter int DATA_W = coeff_rom_pkg::DATA_W
) (
  input  logic              clk,
  input  logic              rst_n,
  coeff_fetch_if.slave      bus,
  output logic [ADDR_W-1:0] rom_addr,
  output logic              rom_ren,
  input  logic [DATA_W-1:0] rom_rdata,
  output logic              busy,
  output logic              done
);
  import coeff_rom_pkg::*;
  state_e state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [12:0] left_q, left_d;
  logic [3:0] stride_q, stride_d;
  logic rv_q, rv_d, rvl_q, rvl_d, done_q, done_d, rdy_q, rdy_d;
  logic [1:0] occ;
  logic fifo_in_ready, pop, ren, accept, last_issue;
  logic [DATA_W:0] fifo_out;
  assign pop        = bus.out_valid && bus.out_ready;
  // Occupancy after this cycle's pop, plus the word on rom_rdata now, must leave room for one more.
  assign ren        = state_q == FETCH && ({1'b0, occ} - {2'b0, pop} + {2'b0, rv_q}) < 3'd2;
  assign accept     = rdy_q && bus.cmd_valid;
  assign last_issue = ren && left_q == 13'd1;
  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    left_d   = left_q;
    stride_d = stride_q;
    done_d   = 1'b0;
    rv_d     = ren;
    rvl_d    = last_issue;
    if (accept) begin
      addr_d   = bus.cmd_base;
      left_d   = bus.cmd_count;
      stride_d = bus.cmd_stride;
      state_d  = bus.cmd_count == 13'd0 ? IDLE : FETCH;
      done_d   = bus.cmd_count == 13'd0;
    end
    if (ren) begin
      addr_d  = addr_q + ADDR_W'(stride_q);
      left_d  = left_q - 13'd1;
      state_d = last_issue ? DRAIN : state_q;
    end
    if (state_q == DRAIN && pop && bus.out_last) begin
      state_d = IDLE;
      done_d  = 1'b1;
    end
    rdy_d = state_d == IDLE;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      addr_q   <= '0;
      left_q   <= '0;
      stride_q <= '0;
      rv_q     <= 1'b0;
      rvl_q    <= 1'b0;
      done_q   <= 1'b0;
      rdy_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      left_q   <= left_d;
      stride_q <= stride_d;
      rv_q     <= rv_d;
      rvl_q    <= rvl_d;
      done_q   <= done_d;
      rdy_q    <= rdy_d;
    end
  end
  // rv_q marks the one cycle rom_rdata holds a requested word; only then is it written.
  coeff_fetch_fifo #(.W(DATA_W + 1)) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (rv_q && fifo_in_ready),
    .in_ready  (fifo_in_ready),
    .in_data   ({rvl_q, rom_rdata}),
    .out_valid (bus.out_valid),
    .out_ready (bus.out_ready),
    .out_data  (fifo_out),
    .count     (occ)
  );
  assign bus.out_last  = fifo_out[DATA_W];
  assign bus.out_data  = fifo_out[DATA_W-1:0];
  assign bus.cmd_ready = rdy_q;
  assign rom_ren       = ren;
  assign rom_addr      = addr_q;
  assign busy          = state_q != IDLE;
  assign done          = done_q;
endmodule

// File: tb/tb_coeff_fetch_engine.sv
// tb_coeff_fetch_engine: directed bench with a rdata=addr ROM model
module tb_coeff_fetch_engine;
  import coeff_rom_pkg::*;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  coeff_fetch_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus();
  logic [ADDR_W-1:0] rom_addr;
  logic rom_ren, busy, done;
  logic [DATA_W-1:0] rom_rdata;
  coeff_fetch_engine #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus.slave),
    .rom_addr  (rom_addr),
    .rom_ren   (rom_ren),
    .rom_rdata (rom_rdata),
    .busy      (busy),
    .done      (done)
  );
  always @(posedge clk) rom_rdata <= rom_ren ? DATA_W'(rom_addr) : '0;
  int checks = 0;
  int failures = 0;
  int cyc = 0;
  always @(posedge clk) cyc++;
  logic [32:0] beats[$];
  int beat_cyc[$];
  int acc_cyc, done_cyc, first_cyc, issued, popped, max_out;
  logic rdy_at_done;
  always @(negedge clk) begin
    if (bus.cmd_valid && bus.cmd_ready) acc_cyc = cyc;
    if (rom_ren) issued++;
    if (bus.out_valid && first_cyc < 0) first_cyc = cyc;
    if (bus.out_valid && bus.out_ready) begin
      beats.push_back({bus.out_last, bus.out_data});
      beat_cyc.push_back(cyc);
      popped++;
    end
    if (issued - popped > max_out) max_out = issued - popped;
    if (done && done_cyc < 0) begin
      done_cyc = cyc;
      rdy_at_done = bus.cmd_ready;
    end
  end
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic clear();
    beats.delete();
    beat_cyc.delete();
    acc_cyc = -1;
    done_cyc = -1;
    first_cyc = -1;
    issued = 0;
    popped = 0;
    max_out = 0;
    rdy_at_done = 1'b0;
  endtask
  task automatic check_reset_vals(input string tag);
    chk({tag, "_rom_ren"}, 32'(rom_ren), 0);
    chk({tag, "_rom_addr"}, 32'(rom_addr), 0);
    chk({tag, "_out_valid"}, 32'(bus.out_valid), 0);
    chk({tag, "_out_data"}, bus.out_data, 0);
    chk({tag, "_out_last"}, 32'(bus.out_last), 0);
    chk({tag, "_busy"}, 32'(busy), 0);
    chk({tag, "_done"}, 32'(done), 0);
    chk({tag, "_cmd_ready"}, 32'(bus.cmd_ready), 0);
  endtask
  task automatic issue(input logic [11:0] base, input logic [12:0] count, input logic [3:0] stride);
    clear();
    chk("cmd_ready_before_cmd", 32'(bus.cmd_ready), 1);
    bus.cmd_valid = 1'b1;
    bus.cmd_base = base;
    bus.cmd_count = count;
    bus.cmd_stride = stride;
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.cmd_valid = 1'b0;
  endtask
  task automatic run(input logic [11:0] base, input logic [12:0] count, input logic [3:0] stride, input bit toggle);
    issue(base, count, stride);
    for (int n = 0; n < 300 && done_cyc < 0; n++) begin
      bus.out_ready = toggle ? ~bus.out_ready : 1'b1;
      @(posedge clk); #1;
    end
    bus.out_ready = 1'b1;
    if (done_cyc < 0) chk("done_timeout", 0, 1);
    chk("beat_count", 32'(beats.size()), 32'(count));
    for (int k = 0; k < beats.size() && k < int'(count); k++) begin
      chk($sformatf("data_%0d", k), beats[k][31:0], 32'((int'(base) + k * int'(stride)) % 4096));
      chk($sformatf("last_%0d", k), 32'(beats[k][32]), 32'(k == int'(count) - 1));
      if (!toggle) chk($sformatf("beat_cyc_%0d", k), 32'(beat_cyc[k] - acc_cyc), 32'(3 + k));
    end
    if (count != 0) begin
      chk("first_valid_latency", 32'(first_cyc - acc_cyc), 3);
      if (beats.size() > 0) chk("done_after_last", 32'(done_cyc - beat_cyc[beats.size() - 1]), 1);
    end else begin
      chk("zero_done_latency", 32'(done_cyc - acc_cyc), 1);
    end
    chk("issued_reads", 32'(issued), 32'(count));
    chk("outstanding_over_2", 32'(max_out > 2), 0);
    chk("cmd_ready_with_done", 32'(rdy_at_done), 1);
  endtask
  initial begin
    bus.cmd_valid = 1'b0;
    bus.cmd_base = '0;
    bus.cmd_count = '0;
    bus.cmd_stride = '0;
    bus.out_ready = 1'b1;
    clear();
    repeat (2) @(posedge clk);
    #1;
    check_reset_vals("por");
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("cmd_ready_after_release", 32'(bus.cmd_ready), 1);
    run(12'h400, 13'd4, 4'd1, 1'b0);
    run(12'hFFE, 13'd4, 4'd1, 1'b0);
    run(12'h600, 13'd6, 4'd2, 1'b1);
    run(12'h123, 13'd0, 4'd1, 1'b0);
    @(posedge clk); #1;
    chk("zero_no_out_valid", 32'(first_cyc), 32'(-1));
    chk("zero_no_rom_ren", 32'(issued), 0);
    issue(12'h800, 13'd8, 4'd1);
    for (int n = 0; n < 50 && beats.size() < 3; n++) begin
      @(posedge clk); #1;
    end
    chk("mid_beats_before_reset", 32'(beats.size()), 3);
    rst_n = 1'b0;
    bus.out_ready = 1'b0;
    @(posedge clk); #1;
    check_reset_vals("mid");
    rst_n = 1'b1;
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    chk("mid_cmd_ready_after_release", 32'(bus.cmd_ready), 1);
    repeat (3) @(posedge clk);
    #1;
    chk("mid_no_done", 32'(done_cyc), 32'(-1));
    chk("mid_no_out_valid", 32'(bus.out_valid), 0);
    run(12'h800, 13'd1, 4'd1, 1'b0);
    run(12'h0A5, 13'd3, 4'd0, 1'b0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
